// File: rtl/gray_sync_rx_if.sv
// Bus between a Gray-code source and gray_sync_rx: the raw Gray word and error
// clear go in; the decoded value, step strobes and error status come out.
interface gray_sync_rx_if #(
    parameter int N         = 8,
    parameter int ERR_CNT_W = 4
);
    logic [N-1:0]         gray_in;
    logic                 err_clr;
    logic [N-1:0]         bin_out;
    logic [N-1:0]         gray_out;
    logic                 change_pulse;
    logic                 resync_pulse;
    logic [N-1:0]         delta;
    logic                 err_multi;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output gray_in, err_clr,
        input  bin_out, gray_out, change_pulse, resync_pulse, delta, err_multi, err_cnt
    );

    modport slave (
        input  gray_in, err_clr,
        output bin_out, gray_out, change_pulse, resync_pulse, delta, err_multi, err_cnt
    );
endinterface

// File: rtl/gray_sync_rx.sv
// Destination-domain receiver for a Gray-coded counter/pointer: synchronizes it,
// accepts changes, decodes to binary and flags transfers that moved more than one bit.
module gray_sync_rx #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 4
) (
    input  logic          clk,
    input  logic          rst,
    gray_sync_rx_if.slave bus
);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic [N-1:0]         sync_q [SYNC_STAGES];
    logic [N-1:0]         gray_q;
    logic [N-1:0]         bin_q;
    logic [N-1:0]         delta_q;
    logic                 change_q;
    logic                 resync_q;
    logic                 err_multi_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic [N-1:0]         gs;
    logic [N-1:0]         gs_bin;
    logic [N-1:0]         diff;
    logic                 step_legal;
    logic                 step_multi;
    logic                 err_multi_d;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // NOTE: the sync chain is a handful of flops, not a RAM, so every stage is
    // reset explicitly; leaving it unreset would let X reach the compare stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= bus.gray_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // NOTE: every signal gets its default before any branch, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        gs          = sync_q[SYNC_STAGES-1];
        gs_bin      = gray2bin(gs);
        diff        = gs ^ gray_q;
        // A nonzero diff with a single set bit is a legal Gray step.
        step_legal  = (diff != '0) && ((diff & (diff - N'(1))) == '0);
        step_multi  = (diff != '0) && !step_legal;

        err_multi_d = err_multi_q;
        err_cnt_d   = err_cnt_q;
        if (bus.err_clr) begin
            err_multi_d = 1'b0;
            err_cnt_d   = '0;
        end
        // Applied after the clear so a coincident error restarts the count at 1.
        if (step_multi) begin
            err_multi_d = 1'b1;
            err_cnt_d   = (err_cnt_d == ERR_MAX) ? ERR_MAX : err_cnt_d + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_q      <= '0;
            bin_q       <= '0;
            delta_q     <= '0;
            change_q    <= 1'b0;
            resync_q    <= 1'b0;
            err_multi_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            change_q    <= step_legal;
            resync_q    <= step_multi;
            delta_q     <= step_legal ? (gs_bin - bin_q) : '0;
            err_multi_q <= err_multi_d;
            err_cnt_q   <= err_cnt_d;
            if (step_legal || step_multi) begin
                gray_q <= gs;
                bin_q  <= gs_bin;
            end
        end
    end

    assign bus.gray_out     = gray_q;
    assign bus.bin_out      = bin_q;
    assign bus.delta        = delta_q;
    assign bus.change_pulse = change_q;
    assign bus.resync_pulse = resync_q;
    assign bus.err_multi    = err_multi_q;
    assign bus.err_cnt      = err_cnt_q;
endmodule
